// File: rtl/seg7_pkg.sv
// Shared segment encodings, FSM state type and decode helpers for the 7-segment capture path.
// Latency: none (constants and combinational functions only).
// Backpressure: none.
package seg7_pkg;

  // Segment bit positions within the 7-bit seg bus.
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] M_A = 7'b1 << SEG_A;
  localparam logic [6:0] M_B = 7'b1 << SEG_B;
  localparam logic [6:0] M_C = 7'b1 << SEG_C;
  localparam logic [6:0] M_D = 7'b1 << SEG_D;
  localparam logic [6:0] M_E = 7'b1 << SEG_E;
  localparam logic [6:0] M_F = 7'b1 << SEG_F;
  localparam logic [6:0] M_G = 7'b1 << SEG_G;

  // Glyphs built from lit segments so the table reads like the display.
  localparam logic [6:0] CODE_0     = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] CODE_1     = M_B | M_C;
  localparam logic [6:0] CODE_2     = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] CODE_3     = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] CODE_4     = M_B | M_C | M_F | M_G;
  localparam logic [6:0] CODE_5     = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] CODE_6     = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] CODE_7     = M_A | M_B | M_C;
  localparam logic [6:0] CODE_8     = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] CODE_9     = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] CODE_9_ALT = M_A | M_B | M_C | M_F | M_G;
  localparam logic [6:0] CODE_A     = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [6:0] CODE_B     = M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] CODE_C     = M_A | M_D | M_E | M_F;
  localparam logic [6:0] CODE_D     = M_B | M_C | M_D | M_E | M_G;
  localparam logic [6:0] CODE_E     = M_A | M_D | M_E | M_F | M_G;
  localparam logic [6:0] CODE_F     = M_A | M_E | M_F | M_G;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Returns {valid, value}; valid is low for any pattern outside the table.
  function automatic logic [4:0] seg7_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      CODE_0:     r = {1'b1, 4'h0};
      CODE_1:     r = {1'b1, 4'h1};
      CODE_2:     r = {1'b1, 4'h2};
      CODE_3:     r = {1'b1, 4'h3};
      CODE_4:     r = {1'b1, 4'h4};
      CODE_5:     r = {1'b1, 4'h5};
      CODE_6:     r = {1'b1, 4'h6};
      CODE_7:     r = {1'b1, 4'h7};
      CODE_8:     r = {1'b1, 4'h8};
      CODE_9:     r = {1'b1, 4'h9};
      CODE_9_ALT: r = {1'b1, 4'h9};
      CODE_A:     r = {1'b1, 4'hA};
      CODE_B:     r = {1'b1, 4'hB};
      CODE_C:     r = {1'b1, 4'hC};
      CODE_D:     r = {1'b1, 4'hD};
      CODE_E:     r = {1'b1, 4'hE};
      CODE_F:     r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // True when exactly one digit-select line is pulled low.
  function automatic logic onehot_low(input logic [3:0] l);
    return (l == 4'b1110) || (l == 4'b1101) || (l == 4'b1011) || (l == 4'b0111);
  endfunction

  // Digit number for a one-hot-low select; only meaningful when onehot_low() holds.
  function automatic logic [1:0] line_index(input logic [3:0] l);
    logic [1:0] r;
    case (l)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus as seen on the panel pins: segments, decimal point and digit selects.
// Latency: none (wiring only).
// Backpressure: none; the display driver owns the bus and the monitor only listens.
interface seg7_scan_capture_if;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] line;

  modport master (output seg, output dp, output line);
  modport slave  (input  seg, input  dp, input  line);
endinterface

// File: rtl/seg7_code_lookup.sv
// Combinational segment-pattern to hex decode, shared with encoder tests.
// Latency: zero cycles.
// Backpressure: none.
module seg7_code_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [4:0] dec
);

  assign dec = seg7_decode(seg);

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the four hex digits shown on a multiplexed 7-segment bus; SEG7_CAPTURE_DP_EN adds dp capture.
// Latency: digit register written STABLE_CYC+2 cycles after a select/pattern first appears stable.
// Backpressure: none; passive monitor, a digit not held stable for STABLE_CYC samples is never captured.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_capture_if.slave  disp,
  output logic [15:0]         digits,
  output logic [3:0]          dig_valid,
  output logic                frame_done,
  output logic                code_err
`ifdef SEG7_CAPTURE_DP_EN
  ,
  output logic [3:0]          dp_flags
`endif
);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int SMP_W = 12;
`else
  localparam int SMP_W = 11;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYC);

  logic [6:0]       seg_s1, seg_s2;
  logic [3:0]       line_s1, line_s2;
  logic [SMP_W-1:0] smp;

  // Two-flop synchroniser on the asynchronous panel bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1  <= '0;
      seg_s2  <= '0;
      line_s1 <= '1;
      line_s2 <= '1;
    end else begin
      seg_s1  <= disp.seg;
      seg_s2  <= seg_s1;
      line_s1 <= disp.line;
      line_s2 <= line_s1;
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  logic dp_s1, dp_s2;

  // dp travels through its own synchroniser so it lines up with seg/line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1 <= 1'b0;
      dp_s2 <= 1'b0;
    end else begin
      dp_s1 <= disp.dp;
      dp_s2 <= dp_s1;
    end
  end

  assign smp = {dp_s2, line_s2, seg_s2};
`else
  logic unused_dp;
  assign unused_dp = disp.dp;
  assign smp       = {line_s2, seg_s2};
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SMP_W-1:0] ref_q, ref_nx;
  logic             cap_try;
  logic             smp_onehot;

  assign smp_onehot = onehot_low(line_s2);

  // FSM, stability counter and reference sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ref_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ref_q <= ref_nx;
    end
  end

  // Next state: wait for a single selected digit, count identical samples, capture once per select period.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ref_nx   = ref_q;
    cap_try  = 1'b0;
    case (state)
      IDLE: begin
        if (smp_onehot) begin
          ref_nx   = smp;
          cnt_nx   = CNT_W'(1);
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (smp == ref_q) begin
          if (cnt >= CNT_LAST) begin
            cnt_nx   = CNT_SAT;
            cap_try  = 1'b1;
            state_nx = HOLD;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end else if (smp_onehot) begin
          ref_nx = smp;
          cnt_nx = CNT_W'(1);
        end else begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (smp != ref_q) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  logic [4:0] dec;
  logic       dec_vld;
  logic [3:0] dec_val;
  logic [1:0] idx;
  logic       cap_ok;
  logic [3:0] cap_bit;
  logic [3:0] frame_mask;

  seg7_code_lookup u_lookup (
    .seg (seg_s2),
    .dec (dec)
  );

  assign dec_vld = dec[4];
  assign dec_val = dec[3:0];
  assign idx     = line_index(ref_q[10:7]);
  assign cap_ok  = cap_try & dec_vld;
  assign cap_bit = cap_ok ? (4'b0001 << idx) : 4'b0000;

  // Capture registers, error pulse and frame tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits     <= '0;
      dig_valid  <= '0;
      code_err   <= 1'b0;
      frame_done <= 1'b0;
      frame_mask <= '0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_flags   <= '0;
`endif
    end else begin
      code_err <= cap_try & ~dec_vld;
      if (cap_ok) begin
        digits[{idx, 2'b00} +: 4] <= dec_val;
        dig_valid[idx]            <= 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
        dp_flags[idx]             <= dp_s2;
`endif
      end
      // A full mask is reported one cycle later and cleared in that same cycle.
      if (frame_mask == 4'hF) begin
        frame_mask <= cap_bit;
        frame_done <= 1'b1;
      end else begin
        frame_mask <= frame_mask | cap_bit;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Monitors a time-multiplexed 4-digit 7-segment bus (seg, dp, line) and recovers each displayed digit as a 4-bit hex value.
- Reverse of the hex-to-segment decoder: segment code back to data, sampled digit by digit across a scan.
- Used as an on-chip loopback and verification monitor in the display path. Its outputs feed status LEDs and the test bench.

Parameters:
- STABLE_CYC, 16: consecutive identical samples required before a digit is accepted (range 2..65535).
- CNT_W, 16: width of the stability counter; must satisfy 2**CNT_W > STABLE_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- seg  in  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dp  in  1  decimal point, active-high.
- line  in  4  digit select, active-low, one-hot-low when valid; bit n selects digit n.
- digits  out  16  captured values; digits[4n+3:4n] holds digit n.
- dig_valid  out  4  bit n set once digit n has been captured at least once since reset.
- frame_done  out  1  one-cycle pulse when all four digits have been captured in the current frame.
- code_err  out  1  one-cycle pulse when a stable pattern is not in the decode table.
- dp_flags  out  4  per-digit dp capture; present only with the optional feature.

Behaviour:
- Inputs are registered through 2 flops (synchroniser) before any use.
- Reset values: digits=0, dig_valid=0, frame_done=0, code_err=0, dp_flags=0. State=IDLE, counter=0, frame mask=0.
- Decode table (seg→value):
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8.
  - 7B or 73→9.
  - 77→A, 1F→b, 4E→C, 3D→d, 4F→E, 47→F.
  - Anything else is an error.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - Stays in IDLE while line is all-high or has more than one bit low.
  - Exactly one bit low → latch {line, seg} as the reference sample, counter=1, go to SETTLE.
- SETTLE:
  - Sample equals the reference → counter++.
  - Sample differs, still one-hot-low → reload the reference, counter=1.
  - Sample differs, not one-hot → go to IDLE.
  - counter reaches STABLE_CYC:
    - If the code is in the table: write the digit, set dig_valid[n], set frame mask bit n.
    - If the code is not in the table: pulse code_err; no register write.
    - In both cases go to HOLD.
- HOLD:
  - Stays in HOLD while the sample equals the reference.
  - Any change → go to IDLE, and sampling restarts next cycle.
  - A digit is therefore captured at most once per contiguous select period.
- Latency: digit register updates exactly STABLE_CYC+2 cycles after the first stable raw input (2 cycles of synchroniser).
- Frame mask:
  - When the mask becomes 4'b1111, frame_done pulses in the following cycle and the mask clears in that same cycle.
  - Re-capturing a digit already set in the mask keeps the mask unchanged.
- Arithmetic: the counter saturates at STABLE_CYC; no wrap-around.
- A blank pattern (seg=0) is not in the table: it produces code_err and no write.
- Reset asserted mid-capture: everything returns to reset values immediately; no partial write.

Optional Feature:
- Macro: SEG7_CAPTURE_DP_EN.
- Defined:
  - dp is part of the reference sample and the stability compare.
  - On capture, dp_flags[n] is written with dp.
  - dp_flags is present in the port list.
- Undefined:
  - dp is ignored entirely (the synchroniser flop may remain unused).
  - dp_flags is absent from the port list.

Decomposition:
- Package seg7_pkg holds:
  - the segment bit-index constants;
  - the 16 code constants plus the alternate 9 code;
  - the state enum;
  - the decode function returning {valid, value[3:0]}.
- Sub-module seg7_code_lookup: combinational decode (7 in, 5 out), shared with future encoder tests.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Hold line=1110, seg=7'h6D for 20 cycles → digits[3:0]=2, dig_valid=0001 at cycle STABLE_CYC+2, no code_err.
- Scan digits 0..3 with codes 30,79,33,47, 20 cycles each → digits=16'hF431, single frame_done pulse after digit 3.
- Hold seg=7'h7E for 10 cycles, then change to 7'h30 and hold 20 cycles (line constant) → first code never captured, digits=1 after the reload.
- line=1100 (two digits selected) for 50 cycles → no capture, state stays IDLE.
- Stable seg=7'h55 on digit 1 → one code_err pulse, digits unchanged, dig_valid[1]=0.
- Assert rst at STABLE_CYC−1 cycles into SETTLE → all outputs 0, no write after release until a fresh STABLE_CYC run.
